// File: rtl/mod_seg7_scan.sv
// Multiplexed N-digit hex seven-segment scan driver with dp, blanking, LZ suppression, dead time, 8-level brightness.
// Latency: one registered cycle from the slot counter/latch to the pins; digit inputs sampled once per slot at cnt==0.
// Backpressure: none; free-running scan, inputs are sampled and never stalled.
// Ports: i_clk/i_rst_n (async active-low); i_digits/i_dp/i_blank/i_lz_suppress/i_bright in;
//        o_seg7/o_dp/o_seg7_nSel active-low display pins; o_frame one-cycle pulse per full scan.
module mod_seg7_scan #(
  parameter int NUM_DIGITS  = 4,
  parameter int DIV_BITS    = 15,
  parameter int DEAD_CYCLES = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [4*NUM_DIGITS-1:0]   i_digits,
  input  logic [NUM_DIGITS-1:0]     i_dp,
  input  logic [NUM_DIGITS-1:0]     i_blank,
  input  logic                      i_lz_suppress,
  input  logic [2:0]                i_bright,
  output logic [6:0]                o_seg7,
  output logic                      o_dp,
  output logic [NUM_DIGITS-1:0]     o_seg7_nSel,
  output logic                      o_frame
);

  localparam int                  CW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0]       LAST_DIGIT = CW'(NUM_DIGITS - 1);
  localparam logic [DIV_BITS-1:0] DEAD       = DIV_BITS'(DEAD_CYCLES);

  logic [DIV_BITS-1:0] cnt;
  logic [CW-1:0]       curr;
  logic                cnt_wrap;

  // Per-slot snapshot of the digit being shown.
  logic [3:0] lat_val;
  logic       lat_dp;
  logic [2:0] lat_bright;
  logic       lat_blank;

  logic [3:0]            sel_val;
  logic                  sel_dp;
  logic                  sel_blank;
  logic                  zero_run;
  logic                  active;
  logic [NUM_DIGITS-1:0] nsel_nxt;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h58;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h27;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
  endfunction

  assign cnt_wrap = &cnt;

  // Select the current digit's inputs. zero_run accumulates "digits 0..k all
  // zero" left to right, which is exactly the leading-zero condition for k.
  always_comb begin
    sel_val   = 4'h0;
    sel_dp    = 1'b0;
    sel_blank = 1'b0;
    zero_run  = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      zero_run = zero_run & (i_digits[4*k +: 4] == 4'h0);
      if (curr == CW'(k)) begin
        sel_val   = i_digits[4*k +: 4];
        sel_dp    = i_dp[k];
        sel_blank = i_blank[k] | (i_lz_suppress & zero_run & (k < NUM_DIGITS - 1));
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt     <= '0;
      curr    <= '0;
      o_frame <= 1'b0;
    end else begin
      cnt     <= cnt + 1'b1;
      o_frame <= cnt_wrap && (curr == LAST_DIGIT);
      if (cnt_wrap) begin
        curr <= (curr == LAST_DIGIT) ? '0 : curr + 1'b1;
      end
    end
  end

  // Loaded at cnt==0; during cnt 0..1 the latch may still hold the previous
  // digit, which the dead time (>= 2 cycles) keeps off the pins.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lat_val    <= 4'h0;
      lat_dp     <= 1'b0;
      lat_bright <= 3'd0;
      lat_blank  <= 1'b1;
    end else if (cnt == '0) begin
      lat_val    <= sel_val;
      lat_dp     <= sel_dp;
      lat_bright <= i_bright;
      lat_blank  <= sel_blank;
    end
  end

  // Brightness compares the slot's top three counter bits (its eighth).
  assign active = (cnt >= DEAD) && (cnt[DIV_BITS-1 -: 3] <= lat_bright) && !lat_blank;

  // Digit 0 is leftmost, i.e. the MSB of the select bus.
  always_comb begin
    nsel_nxt = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      nsel_nxt[NUM_DIGITS-1-k] = ~(active && (curr == CW'(k)));
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_seg7      <= 7'h7F;
      o_dp        <= 1'b1;
      o_seg7_nSel <= '1;
    end else begin
      o_seg7      <= active ? glyph(lat_val) : 7'h7F;
      o_dp        <= ~(active & lat_dp);
      o_seg7_nSel <= nsel_nxt;
    end
  end

endmodule

// File: tb/tb_mod_seg7_scan.sv
module tb_mod_seg7_scan;

  logic        clk;
  logic        rst_n;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic        lz;
  logic [2:0]  bright;
  logic [6:0]  seg;
  logic        odp;
  logic [3:0]  nsel;
  logic        frame;

  mod_seg7_scan #(.NUM_DIGITS(4), .DIV_BITS(6), .DEAD_CYCLES(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_digits(digits), .i_dp(dp), .i_blank(blank),
    .i_lz_suppress(lz), .i_bright(bright), .o_seg7(seg), .o_dp(odp),
    .o_seg7_nSel(nsel), .o_frame(frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h58,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E};

  // Reference model: e = clock edges since reset release. Cycle e shows slot
  // e/64 at position e%64; pins after edge e reflect cycle e-1.
  int          e;
  int          s_digit;
  logic [3:0]  s_val;
  logic        s_dp;
  logic        s_blank;
  logic [2:0]  s_bright;
  logic [12:0] exp_out;
  logic        exp_lit;

  task automatic step();
    int c;
    int d;
    int mask;
    logic [15:0] sh;
    logic [3:0]  en;
    logic [6:0]  es;
    if (e % 64 == 0) begin
      s_digit  = (e / 64) % 4;
      sh       = digits >> (4 * s_digit);
      s_val    = sh[3:0];
      s_dp     = dp[s_digit];
      s_bright = bright;
      mask     = (1 << (4 * (s_digit + 1))) - 1;
      s_blank  = blank[s_digit] || (lz && s_digit < 3 && ((int'(digits) & mask) == 0));
    end
    @(posedge clk);
    e++;
    #1;
    c = (e - 1) % 64;
    d = ((e - 1) / 64) % 4;
    exp_lit = (c >= 2) && (c < (int'(s_bright) + 1) * 8) && !s_blank;
    en = 4'hF;
    es = 7'h7F;
    if (exp_lit) begin
      en[3-d] = 1'b0;
      es = glyph_tab[s_val];
    end
    exp_out = {es, ~(exp_lit & s_dp), en, (e % 256 == 0)};
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    digits = 16'h4321;
    dp     = 4'h0;
    blank  = 4'h0;
    lz     = 1'b0;
    bright = 3'd7;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({seg, odp, nsel, frame} !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_hold got=%h exp=%h", {seg, odp, nsel, frame}, {7'h7F, 1'b1, 4'hF, 1'b0});
    end
    #2 rst_n = 1'b1;
    e = 0;
    s_blank = 1'b1;
    vectors++;
    if ({seg, odp, nsel, frame} !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_release got=%h exp=%h", {seg, odp, nsel, frame}, {7'h7F, 1'b1, 4'hF, 1'b0});
    end
  endtask

  task automatic test_basic_scan();
    for (int i = 0; i < 256; i++) begin
      step();
      vectors++;
      if ({seg, odp, nsel, frame} !== exp_out) begin
        miscompares++;
        $display("FAIL basic_scan e=%0d got=%h exp=%h", e, {seg, odp, nsel, frame}, exp_out);
      end
    end
  endtask

  task automatic test_brightness();
    int lit;
    int want [4] = '{6, 30, 14, 62};
    for (int s = 0; s < 4; s++) begin
      bright = (s == 0) ? 3'd0 : (s == 1) ? 3'd3 : (s == 2) ? 3'd1 : 3'd7;
      lit = 0;
      for (int i = 0; i < 64; i++) begin
        step();
        if (nsel !== 4'hF) lit++;
        vectors++;
        if ({seg, odp, nsel, frame} !== exp_out) begin
          miscompares++;
          $display("FAIL brightness e=%0d got=%h exp=%h", e, {seg, odp, nsel, frame}, exp_out);
        end
        // Mid-slot change must not affect the slot already running.
        if (s == 2 && i == 9) bright = 3'd7;
      end
      vectors++;
      if (lit != want[s]) begin
        miscompares++;
        $display("FAIL bright_ontime slot=%0d got=%0d exp=%0d", s, lit, want[s]);
      end
    end
  endtask

  task automatic test_lz();
    logic [15:0] pat [3] = '{16'h5000, 16'h0000, 16'h0000};
    for (int p = 0; p < 3; p++) begin
      digits = pat[p];
      lz = (p < 2);
      bright = 3'(2 + p);
      for (int i = 0; i < 256; i++) begin
        step();
        vectors++;
        if ({seg, odp, nsel, frame} !== exp_out) begin
          miscompares++;
          $display("FAIL lz_suppress p=%0d e=%0d got=%h exp=%h", p, e, {seg, odp, nsel, frame}, exp_out);
        end
      end
    end
    lz = 1'b0;
  endtask

  task automatic test_blank_dp();
    blank  = 4'b0010;
    dp     = 4'b0001;
    digits = 16'($urandom);
    bright = 3'($urandom_range(0, 7));
    for (int i = 0; i < 256; i++) begin
      step();
      vectors++;
      if ({seg, odp, nsel, frame} !== exp_out) begin
        miscompares++;
        $display("FAIL blank_dp e=%0d got=%h exp=%h", e, {seg, odp, nsel, frame}, exp_out);
      end
    end
    blank = 4'h0;
    dp    = 4'h0;
  endtask

  task automatic test_mid_slot_change();
    bright = 3'd7;
    digits = {digits[15:4], 4'h1};
    while (e % 256 != 0) begin
      step();
      vectors++;
      if ({seg, odp, nsel, frame} !== exp_out) begin
        miscompares++;
        $display("FAIL mid_align e=%0d got=%h exp=%h", e, {seg, odp, nsel, frame}, exp_out);
      end
    end
    for (int i = 0; i < 320; i++) begin
      step();
      if (e % 256 == 20) digits = {digits[15:4], 4'hA};
      vectors++;
      if ({seg, odp, nsel, frame} !== exp_out) begin
        miscompares++;
        $display("FAIL mid_slot_change e=%0d got=%h exp=%h", e, {seg, odp, nsel, frame}, exp_out);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      step();
      vectors++;
      if ({seg, odp, nsel, frame} !== exp_out) begin
        miscompares++;
        $display("FAIL random e=%0d got=%h exp=%h", e, {seg, odp, nsel, frame}, exp_out);
      end
      if ($urandom_range(0, 15) == 0) begin
        digits = 16'($urandom);
        dp     = 4'($urandom);
        blank  = 4'($urandom) & 4'($urandom);
        lz     = 1'($urandom);
        bright = 3'($urandom);
      end
    end
  endtask

  task automatic test_async_reset();
    int first_frame;
    digits = 16'h9876;
    blank  = 4'h0;
    lz     = 1'b0;
    bright = 3'd7;
    while (e % 256 != 128 + 30) begin
      step();
      vectors++;
      if ({seg, odp, nsel, frame} !== exp_out) begin
        miscompares++;
        $display("FAIL arst_align e=%0d got=%h exp=%h", e, {seg, odp, nsel, frame}, exp_out);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({seg, odp, nsel, frame} !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
      miscompares++;
      $display("FAIL arst_immediate got=%h exp=%h", {seg, odp, nsel, frame}, {7'h7F, 1'b1, 4'hF, 1'b0});
    end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    e = 0;
    s_blank = 1'b1;
    first_frame = -1;
    for (int i = 0; i < 600; i++) begin
      step();
      if (frame === 1'b1 && first_frame < 0) first_frame = e;
      vectors++;
      if ({seg, odp, nsel, frame} !== exp_out) begin
        miscompares++;
        $display("FAIL arst_resume e=%0d got=%h exp=%h", e, {seg, odp, nsel, frame}, exp_out);
      end
    end
    vectors++;
    if (first_frame != 256) begin
      miscompares++;
      $display("FAIL arst_first_frame got=%0d exp=256", first_frame);
    end
  endtask

  initial begin
    e = 0;
    s_blank = 1'b1;
    test_reset();
    test_basic_scan();
    test_brightness();
    test_lz();
    test_blank_dp();
    test_mid_slot_change();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
